// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: buffers received UART bytes in a DEPTH-entry FIFO and
// retransmits them through the serial_tx send/ready handshake. It provides
// hysteresis flow control (cts), a hold mode (loop_en=0), flush, and sticky
// overflow plus saturating drop and framing-error counters.
module uart_loop_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int CTS_HI     = 2**DEPTH_LOG2 - 2,
    parameter int CTS_LO     = 2**DEPTH_LOG2 / 2,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_finish,
    input  logic                  rx_error,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_send,
    input  logic                  tx_ready,
    input  logic                  loop_en,
    input  logic                  flush,
    input  logic                  clr_flags,
    output logic                  cts,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [DATA_W-1:0]     last_rx
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] DEPTH_LV  = LW'(DEPTH);
    localparam logic [LW-1:0] CTS_HI_LV = LW'(CTS_HI);
    localparam logic [LW-1:0] CTS_LO_LV = LW'(CTS_LO);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_WAIT = 2'd1,
        DONE_WAIT = 2'd2
    } tx_state_t;

    tx_state_t             state;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [LW-1:0]         level_next;

    logic full;
    logic empty;
    logic push_req;
    logic err_ev;
    logic pop;
    logic push;
    logic drop;

    // Full is taken from the occupancy count so every slot is usable.
    assign full     = (level == DEPTH_LV);
    assign empty    = (level == '0);
    assign push_req = rx_finish & ~rx_error;
    assign err_ev   = rx_finish & rx_error;
    // A pop only launches from IDLE; flush blocks new pops but not in-flight ones.
    assign pop      = (state == IDLE) & loop_en & ~empty & tx_ready & ~flush;
    // A full FIFO still accepts a byte when a slot frees in the same cycle.
    assign push     = push_req & ~flush & (~full | pop);
    // A byte swallowed by flush is not a drop.
    assign drop     = push_req & ~flush & full & ~pop;

    // Next occupancy: flush wins, simultaneous push and pop cancel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Byte storage, written on accepted pushes.
    // NOTE: the storage array has no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= rx_data;
        end
    end

    // Pointers, occupancy and hysteresis flow control.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            cts   <= 1'b0;
        end else begin
            level <= level_next;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + DEPTH_LOG2'(1);
                end
                if (pop) begin
                    rptr <= rptr + DEPTH_LOG2'(1);
                end
            end
            if (level_next >= CTS_HI_LV) begin
                cts <= 1'b1;
            end else if (level_next <= CTS_LO_LV) begin
                cts <= 1'b0;
            end
        end
    end

    // Last good byte, sticky overflow and saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rx  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (push_req) begin
                last_rx <= rx_data;
            end
            if (clr_flags) begin
                overflow <= drop;
                drop_cnt <= drop ? CNT_W'(1) : '0;
                err_cnt  <= err_ev ? CNT_W'(1) : '0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + CNT_W'(1);
                    end
                end
                if (err_ev && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Transmit handshake FSM with registered tx_send and tx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_send <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rptr];
                        tx_send <= 1'b1;
                        state   <= BUSY_WAIT;
                    end
                end
                BUSY_WAIT: begin
                    if (!tx_ready) begin
                        tx_send <= 1'b0;
                        state   <= DONE_WAIT;
                    end
                end
                DONE_WAIT: begin
                    if (tx_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
